// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 definitions.
//   op_e          request operation codes (11-15 are illegal)
//   OPC_*         fixed opcode fields, sized to the format they head
//   *_MIN/*_MAX   signed immediate limits per format
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_ORR  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADDI = 4'd4,
    OP_SUBI = 4'd5,
    OP_MOVZ = 4'd6,
    OP_B    = 4'd7,
    OP_CBZ  = 4'd8,
    OP_LDUR = 4'd9,
    OP_STUR = 4'd10
  } op_e;

  // 11-bit: R-type and D-type
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // 10-bit: I-type
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  // 9-bit: IW-type
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
  // 8-bit: CB-type
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  // 6-bit: B-type
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam int ADDI_MIN = 0;
  localparam int ADDI_MAX = 4095;
  localparam int DT_MIN   = -256;
  localparam int DT_MAX   = 255;
  localparam int MOVZ_MIN = 0;
  localparam int MOVZ_MAX = 65535;
  localparam int CB_MIN   = -(1 << 18);
  localparam int CB_MAX   = (1 << 18) - 1;
  localparam int B_MIN    = -(1 << 25);
  localparam int B_MAX    = (1 << 25) - 1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO, all outputs derived from registers.
//   clk, rst_n   clock, async active-low reset
//   clear        synchronous flush, wins over push/pop
//   push, din    write side (caller guarantees !full)
//   pop, dout    read side, dout is the head entry (caller guarantees !empty)
//   empty, full  occupancy flags
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;

  // Entries are zeroed on flush too so the head reads 0 after reset/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + AW'(1);
      end
      if (pop) r_rp <= r_rp + AW'(1);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rp];
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == (AW+1)'(DEPTH));

endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: encodes LEGv8 instruction requests into 32-bit words
// and streams them into an instruction memory through a small buffer.
//   clk, rst_n          clock, async active-low reset
//   clear               synchronous flush of buffer, address and counters
//   in_valid/in_ready   request handshake
//   in_op, in_rd/rn/rm  operation and register fields (in_rd = Rt for D/CB)
//   in_imm, in_hw       immediate/offset and MOVZ shift selector
//   imem_we/addr/wdata  memory write port, mem_ready accepts a write
//   err                 one-cycle pulse after a rejected request
//   words_written       completed writes (wraps), err_count rejects (saturates)
module legv8_instr_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [31:0]       in_imm,
  input  logic [1:0]        in_hw,
  output logic              imem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic [15:0]       words_written,
  output logic [7:0]        err_count
);

  logic signed [31:0] w_simm;
  logic [31:0]        w_word;
  logic               w_legal;
  logic               w_xfer, w_push, w_pop;
  logic               w_empty, w_full;
  logic [31:0]        w_head;

  logic [ADDR_W-1:0]  r_addr;
  logic [15:0]        r_words;
  logic [7:0]         r_errcnt;
  logic               r_err;

  assign w_simm = $signed(in_imm);

  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (op_e'(in_op))
      OP_AND:  begin w_word = {OPC_AND, in_rm, 6'd0, in_rn, in_rd}; w_legal = 1'b1; end
      OP_ORR:  begin w_word = {OPC_ORR, in_rm, 6'd0, in_rn, in_rd}; w_legal = 1'b1; end
      OP_ADD:  begin w_word = {OPC_ADD, in_rm, 6'd0, in_rn, in_rd}; w_legal = 1'b1; end
      OP_SUB:  begin w_word = {OPC_SUB, in_rm, 6'd0, in_rn, in_rd}; w_legal = 1'b1; end
      OP_ADDI: begin
        w_word  = {OPC_ADDI, in_imm[11:0], in_rn, in_rd};
        w_legal = (w_simm >= ADDI_MIN) && (w_simm <= ADDI_MAX);
      end
      OP_SUBI: begin
        w_word  = {OPC_SUBI, in_imm[11:0], in_rn, in_rd};
        w_legal = (w_simm >= ADDI_MIN) && (w_simm <= ADDI_MAX);
      end
      OP_LDUR: begin
        w_word  = {OPC_LDUR, in_imm[8:0], 2'b00, in_rn, in_rd};
        w_legal = (w_simm >= DT_MIN) && (w_simm <= DT_MAX);
      end
      OP_STUR: begin
        w_word  = {OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
        w_legal = (w_simm >= DT_MIN) && (w_simm <= DT_MAX);
      end
      OP_MOVZ: begin
        w_word  = {OPC_MOVZ, in_hw, in_imm[15:0], in_rd};
        w_legal = (w_simm >= MOVZ_MIN) && (w_simm <= MOVZ_MAX);
      end
      OP_CBZ: begin
        w_word  = {OPC_CBZ, in_imm[18:0], in_rd};
        w_legal = (w_simm >= CB_MIN) && (w_simm <= CB_MAX);
      end
      OP_B: begin
        w_word  = {OPC_B, in_imm[25:0]};
        w_legal = (w_simm >= B_MIN) && (w_simm <= B_MAX);
      end
      default: begin w_word = '0; w_legal = 1'b0; end
    endcase
  end

  // Ready comes from the registered full flag only, so a full buffer
  // refuses input even in a cycle where it is also draining.
  assign in_ready = !w_full && !clear;
  assign w_xfer   = in_valid && in_ready;
  assign w_push   = w_xfer && w_legal;
  assign w_pop    = !w_empty && mem_ready;

  sync_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (w_push),
    .din   (w_word),
    .pop   (w_pop),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_words  <= '0;
      r_errcnt <= '0;
      r_err    <= 1'b0;
    end else if (clear) begin
      r_addr   <= '0;
      r_words  <= '0;
      r_errcnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_xfer && !w_legal;
      if (w_xfer && !w_legal && (r_errcnt != 8'hFF)) r_errcnt <= r_errcnt + 8'd1;
      if (w_pop) begin
        r_addr  <= r_addr + ADDR_W'(4);
        r_words <= r_words + 16'd1;
      end
    end
  end

  assign imem_we       = !w_empty;
  assign imem_wdata    = w_head;
  assign imem_addr     = r_addr;
  assign err           = r_err;
  assign words_written = r_words;
  assign err_count     = r_errcnt;

endmodule

// File: doc/legv8_instr_encoder.md
LEGV8_INSTR_ENCODER -- requirements
Module: legv8_instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of the instruction-memory write port.
REQ-002 Parameter DEPTH, default 2, number of entries in the encoded-word buffer (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clear  input  1  synchronous flush: empties the buffer and zeroes the address and counters.
REQ-006 in_valid, in_ready  input/output  1 each  request handshake; transfer when both are high at a rising edge.
REQ-007 in_op  input  4  operation: 0 AND, 1 ORR, 2 ADD, 3 SUB, 4 ADDI, 5 SUBI, 6 MOVZ, 7 B, 8 CBZ, 9 LDUR, 10 STUR; codes 11-15 are illegal.
REQ-008 in_rd, in_rn, in_rm  input  5 each  register fields; in_rd carries Rt for LDUR, STUR and CBZ.
REQ-009 in_imm  input  32  two's-complement immediate or offset (word offset for B and CBZ).
REQ-010 in_hw  input  2  MOVZ shift selector.
REQ-011 imem_we  output  1  write strobe; mem_ready  input  1  memory accepts the write when high.
REQ-012 imem_addr  output  ADDR_W  byte address; imem_wdata  output  32  encoded instruction.
REQ-013 err  output  1  one-cycle pulse for a rejected request.
REQ-014 words_written  output  16  count of completed writes; err_count  output  8  count of rejected requests.

Function
REQ-015 Encodings, with bit 31 on the left:
- R-type (AND, ORR, ADD, SUB): opcode 10001010000 / 10101010000 / 10001011000 / 11001011000, then Rm, then shamt 000000, then Rn, then Rd.
- ADDI / SUBI: opcode 1001000100 / 1101000100, then imm[11:0], then Rn, then Rd.
- LDUR / STUR: opcode 11111000010 / 11111000000, then imm[8:0], then 00, then Rn, then Rt.
- MOVZ: opcode 110100101, then hw, then imm[15:0], then Rd.
- CBZ: opcode 10110100, then imm[18:0], then Rt.
- B: opcode 000101, then imm[25:0].
REQ-016 Immediate range checks; a request that fails its check is rejected:
- ADDI and SUBI: 0 to 4095.
- LDUR and STUR: -256 to 255.
- MOVZ: 0 to 65535.
- CBZ: -2^18 to 2^18-1.
- B: -2^25 to 2^25-1.
REQ-017 Rejected request (illegal op or range failure): consumes the handshake, writes nothing to the buffer, pulses err in the following cycle, increments err_count (saturating at 255).
REQ-018 Accepted legal request: the encoded word enters the buffer at the transfer edge.
REQ-019 in_ready = (buffer occupancy < DEPTH) AND NOT clear, driven only from registered state; it never depends on mem_ready.
REQ-020 imem_we = buffer not empty; imem_wdata = head entry; both are registered.
REQ-021 Write completes at an edge where imem_we and mem_ready are both high:
- the head entry pops;
- imem_addr increments by 4, modulo 2^ADDR_W (wraps to 0);
- words_written increments, wrapping modulo 2^16.
REQ-022 Minimum latency: 1 cycle. A word accepted at edge k presents imem_we high during cycle k+1.
REQ-023 Sustained throughput: one word per cycle while mem_ready stays high.
REQ-024 A push and a pop in the same cycle leave occupancy unchanged and preserve FIFO order.
REQ-025 While mem_ready is low, imem_we, imem_addr and imem_wdata hold stable.
REQ-026 clear has priority over push and pop in the same cycle:
- the buffer empties and the in-flight write is dropped;
- imem_addr, words_written and err_count go to 0;
- an input transfer in that cycle is not possible because in_ready is low.

Reset
REQ-027 While rst_n is low, asynchronously:
- imem_we = 0, imem_addr = 0, imem_wdata = 0;
- err = 0, words_written = 0, err_count = 0;
- buffer empty, so in_ready = 1 after release.
REQ-028 Reset asserted mid-stream discards all buffered words; no imem_we pulse follows the reset release until a new request is accepted.

Structure
REQ-029 A shared package legv8_pkg SHALL hold:
- the op-code enumeration;
- the 11-, 10-, 9-, 8- and 6-bit opcode constants;
- the immediate range limits.
The existing control decoder SHALL use the same package constants.
REQ-030 The buffer SHALL be one sub-module, sync_fifo, parameterised by width and DEPTH. Encoding and range checking SHALL be combinational logic in the top module.

Verification
REQ-031 ADD X3,X1,X2 (op 2, rd 3, rn 1, rm 2) with mem_ready=1 -> imem_we high the next cycle, imem_wdata 0x8B020023, imem_addr 0.
REQ-032 LDUR X5,[X2,#-8] then MOVZ X7,#0x1234,hw 1 -> words 0xF85F8045 then 0xD2A24687 at addresses 0 and 4.
REQ-033 ADDI with imm 4096, then op 12 -> two err pulses, err_count 2, no imem_we.
REQ-034 mem_ready=0 while three requests are offered -> two accepted, in_ready low, outputs stable. mem_ready=1 -> writes in order at consecutive addresses, then in_ready returns high.
REQ-035 Start at address 2^ADDR_W-4 and complete two writes -> the second write goes to address 0. words_written increments by 2.
REQ-036 rst_n pulsed low with two words buffered -> all outputs zero immediately, no writes after release. clear mid-stream -> same result synchronously.
